// File: rtl/sync_fifo_pkg.sv
// Shared widths and status decode for the single-clock FIFO controller.
// Pure declarations, no latency; carries no flow-control behaviour of its own.
package sync_fifo_pkg;

    localparam int ADDRESS_SIZE_DFLT = 5;

    typedef logic [ADDRESS_SIZE_DFLT-1:0] ptr_t;
    typedef logic [ADDRESS_SIZE_DFLT:0]   count_t;

    typedef struct packed {
        logic afull;
        logic aempty;
    } almost_t;

    function automatic almost_t almost_flags(input int unsigned cnt,
                                             input int unsigned afull_thresh,
                                             input int unsigned aempty_thresh);
        almost_t f;
        f.afull  = (cnt >= afull_thresh);
        f.aempty = (cnt <= aempty_thresh);
        return f;
    endfunction

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM: one write port and one registered read port (1-cycle latency).
// No backpressure; read data holds while read is low, and a same-address write is not forwarded.
module dual_port_memory #(
    parameter int BITSIZE      = 8,
    parameter int MEMSIZE      = 32,
    parameter int ADDRESS_SIZE = 5
) (
    input  logic                    wclk,
    input  logic                    write,
    input  logic [ADDRESS_SIZE-1:0] wadrs,
    input  logic [BITSIZE-1:0]      wdata,
    input  logic                    rclk,
    input  logic                    read,
    input  logic [ADDRESS_SIZE-1:0] radrs,
    output logic [BITSIZE-1:0]      rdata
);

    logic [BITSIZE-1:0] mem_q [MEMSIZE];
    logic [BITSIZE-1:0] rdata_q;

    always_ff @(posedge wclk) begin
        if (write) begin
            mem_q[wadrs] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (read) begin
            rdata_q <= mem_q[radrs];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around a dual-port RAM; read data and rvalid one cycle after pop.
// Push while full is rejected unless a pop is accepted in the same cycle; rejects set sticky errors.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int BITSIZE       = 8,
    parameter int ADDRESS_SIZE  = 5,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [BITSIZE-1:0]    wdata,
    input  logic                  pop,
    output logic [BITSIZE-1:0]    rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDRESS_SIZE:0] count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int MEMSIZE = 2 ** ADDRESS_SIZE;

    logic [ADDRESS_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDRESS_SIZE-1:0] rptr_q, rptr_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic                    rvalid_q, rvalid_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    push_ok, pop_ok;
    almost_t                 almost;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (ADDRESS_SIZE+1)'(MEMSIZE));
    assign almost  = almost_flags(32'(count_q), AFULL_THRESH, AEMPTY_THRESH);

    // No bypass: a pop on empty is rejected even alongside a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rvalid_d    = pop_ok;
        overflow_d  = (push && !push_ok) || (overflow_q && !clr_err);
        underflow_d = (pop && !pop_ok) || (underflow_q && !clr_err);
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rvalid_q    <= rvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    dual_port_memory #(
        .BITSIZE      (BITSIZE),
        .MEMSIZE      (MEMSIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_mem (
        .wclk  (clk),
        .write (push_ok),
        .wadrs (wptr_q),
        .wdata (wdata),
        .rclk  (clk),
        .read  (pop_ok),
        .radrs (rptr_q),
        .rdata (rdata)
    );

    assign rvalid       = rvalid_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign almost_full  = almost.afull;
    assign almost_empty = almost.aempty;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with hand-computed expectations and a reference queue for the random phase.
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic [7:0] wdata;
    logic       pop;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_ctrl #(
        .BITSIZE       (8),
        .ADDRESS_SIZE  (5),
        .AFULL_THRESH  (28),
        .AEMPTY_THRESH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .wdata        (wdata),
        .pop          (pop),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        wdata   = 8'h00;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_word;
    logic       m_pop_ok;
    logic       m_push_ok;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        check("rst_empty",  32'(empty), 1);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_count",  32'(count), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_full",   32'(full), 0);
        check("rst_afull",  32'(almost_full), 0);
        check("rst_ovf",    32'(overflow), 0);
        check("rst_udf",    32'(underflow), 0);

        // Fill with 0x01..0x20
        for (int i = 1; i <= 32; i++) begin
            push  = 1'b1;
            wdata = 8'(i);
            cyc();
            check("fill_count", 32'(count), i);
            check("fill_afull", 32'(almost_full), (i >= 28) ? 1 : 0);
            check("fill_full",  32'(full), (i == 32) ? 1 : 0);
        end
        push = 1'b0;

        // Back-to-back drain
        for (int i = 1; i <= 32; i++) begin
            pop = 1'b1;
            cyc();
            check("drain_rvalid", 32'(rvalid), 1);
            check("drain_rdata",  32'(rdata), i);
            check("drain_aempty", 32'(almost_empty), ((32 - i) <= 4) ? 1 : 0);
        end
        pop = 1'b0;
        cyc();
        check("drain_rvalid_off", 32'(rvalid), 0);
        check("drain_empty",      32'(empty), 1);
        check("drain_udf",        32'(underflow), 0);

        // Fill with 0x40..0x5F, then overflow
        for (int i = 0; i < 32; i++) begin
            push  = 1'b1;
            wdata = 8'(8'h40 + i);
            cyc();
        end
        check("full_again", 32'(full), 1);
        wdata = 8'hAA;
        cyc();
        push = 1'b0;
        check("ovf_set",   32'(overflow), 1);
        check("ovf_count", 32'(count), 32);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        // Push and pop together while full
        push  = 1'b1;
        pop   = 1'b1;
        wdata = 8'h55;
        cyc();
        push = 1'b0;
        check("fullpp_rvalid", 32'(rvalid), 1);
        check("fullpp_rdata",  32'(rdata), 32'h40);
        check("fullpp_count",  32'(count), 32);
        check("fullpp_ovf",    32'(overflow), 0);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            check("fullpp_drain", 32'(rdata), (i == 32) ? 32'h55 : 32'(8'h40 + i));
        end
        pop = 1'b0;
        cyc();
        check("fullpp_empty", 32'(empty), 1);

        // Push and pop together while empty: pop rejected
        push  = 1'b1;
        pop   = 1'b1;
        wdata = 8'h77;
        cyc();
        push = 1'b0;
        check("emptypp_udf",    32'(underflow), 1);
        check("emptypp_count",  32'(count), 1);
        check("emptypp_rvalid", 32'(rvalid), 0);
        cyc();
        pop = 1'b0;
        check("emptypp_rvalid2", 32'(rvalid), 1);
        check("emptypp_rdata",   32'(rdata), 32'h77);
        check("emptypp_empty",   32'(empty), 1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("udf_clr", 32'(underflow), 0);

        // Random traffic against a reference queue
        q.delete();
        for (int n = 0; n < 100; n++) begin
            push  = 1'($urandom_range(0, 1));
            pop   = 1'($urandom_range(0, 1));
            wdata = 8'($urandom_range(0, 255));
            m_pop_ok  = pop && (q.size() != 0);
            m_push_ok = push && ((q.size() < 32) || m_pop_ok);
            exp_word  = 8'h00;
            if (m_pop_ok) exp_word = q.pop_front();
            if (m_push_ok) q.push_back(wdata);
            cyc();
            check("rnd_rvalid", 32'(rvalid), 32'(m_pop_ok));
            if (m_pop_ok) check("rnd_rdata", 32'(rdata), 32'(exp_word));
            check("rnd_count", 32'(count), q.size());
        end
        idle_inputs();

        // Reset with a pop in flight at count 10
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push  = 1'b1;
            wdata = 8'(8'hC0 + i);
            cyc();
        end
        push = 1'b0;
        check("pre_rst_count", 32'(count), 10);
        pop = 1'b1;
        cyc();
        check("pre_rst_rvalid", 32'(rvalid), 1);
        check("pre_rst_rdata",  32'(rdata), 32'hC0);
        rst_n   = 1'b0;
        push    = 1'b1;
        clr_err = 1'b0;
        cyc();
        check("rst_mid_rvalid", 32'(rvalid), 0);
        check("rst_mid_count",  32'(count), 0);
        check("rst_mid_empty",  32'(empty), 1);
        check("rst_mid_ovf",    32'(overflow), 0);
        check("rst_mid_udf",    32'(underflow), 0);
        idle_inputs();
        rst_n = 1'b1;
        cyc();
        check("post_rst_empty", 32'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences one dual_port_memory instance with both memory clock pins tied to clk. It owns the read and write pointers, the occupancy count, and the status flags. It converts push/pop requests into memory write/read strobes and addresses, and produces a read-valid strobe aligned to the memory's registered read data. It serves as the same-clock counterpart to the async FIFO, for buffering inside one clock domain.

Parameters:
BITSIZE, 8, data word width.
ADDRESS_SIZE, 5, memory address width; depth MEMSIZE = 2**ADDRESS_SIZE is fixed and not a separate parameter.
AFULL_THRESH, 28, almost_full asserts when count >= this value.
AEMPTY_THRESH, 4, almost_empty asserts when count <= this value.

Ports:
clk  in  1  single clock; drives the controller and both memory ports.
rst_n  in  1  synchronous active-low reset.
push  in  1  write request.
wdata  in  BITSIZE  write data, sampled with an accepted push.
pop  in  1  read request.
rdata  out  BITSIZE  read data, valid only while rvalid=1.
rvalid  out  1  read data strobe, one cycle after an accepted pop.
full  out  1  count == MEMSIZE.
empty  out  1  count == 0.
almost_full  out  1  count >= AFULL_THRESH.
almost_empty  out  1  count <= AEMPTY_THRESH.
count  out  ADDRESS_SIZE+1  current occupancy, 0..MEMSIZE.
overflow  out  1  sticky: a push was rejected.
underflow  out  1  sticky: a pop was rejected.
clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst_n=0 at posedge clk): wptr=0, rptr=0, count=0, rvalid=0, overflow=0, underflow=0.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - Reset dominates all other inputs, including push, pop and clr_err in the same cycle.
  - An in-flight rvalid is cancelled.
  - Memory contents are not cleared and are unreachable after reset.
  - rdata is undefined until the first rvalid.
- Pointers: ADDRESS_SIZE bits each, wrapping naturally from MEMSIZE-1 to 0. The memory address ports are driven with these pointers directly.
- Pop acceptance: pop_ok = pop && !empty. There is no bypass, so a pop while empty is rejected even if a push occurs in the same cycle.
- Push acceptance: push_ok = push && (!full || pop_ok). Push while full is accepted only with a simultaneous accepted pop.
  - In that case wptr == rptr. The memory returns the old word because the read samples before the write update.
- Memory strobes: mem.write = push_ok, mem.wadrs = wptr, mem.wdata = wdata; mem.read = pop_ok, mem.radrs = rptr. All are combinational from the current cycle.
- Pointer update: wptr increments on push_ok; rptr increments on pop_ok.
- Count update, next-cycle:
  - count+1 on push_ok only.
  - count-1 on pop_ok only.
  - Unchanged when both or neither occur.
- Status flags are combinational decodes of the registered count.
- Read latency: rvalid is registered and equals the previous cycle's pop_ok. rdata is the memory rdata output, which holds its value when rvalid=0.
  - Back-to-back pops produce back-to-back rvalid with consecutive words.
- Error flags:
  - overflow sets on push && !push_ok.
  - underflow sets on pop && !pop_ok.
  - Both clear on clr_err.
  - If clr_err and a new error occur in the same cycle, set wins.
  - A rejected request does not change pointers, count or memory.
- No state machine beyond the pointers, count and rvalid register. FIFO order is strict.

Decomposition:
- Package sync_fifo_pkg holds the count_t and ptr_t width typedefs derived from ADDRESS_SIZE, and a function computing the almost-flag comparisons.
- One sub-module: dual_port_memory (BITSIZE, MEMSIZE=2**ADDRESS_SIZE, ADDRESS_SIZE), instantiated with wclk=rclk=clk.
- Pointer, count and flag logic stays in sync_fifo_ctrl.

Test Plan:
- Reset then idle: empty=1, almost_empty=1, count=0, rvalid=0, full=0, no error flags.
- Push 0x01..0x20 (32 words), then pop 32 times back-to-back:
  - full=1 after the 32nd push; almost_full=1 from count 28.
  - rvalid for 32 consecutive cycles, each one cycle after its pop, with rdata 0x01..0x20 in order.
  - empty=1 at the end.
- Fill to full, then push 0xAA with no pop: overflow=1, count stays 32. Pulse clr_err: overflow=0.
- Full plus simultaneous push 0x55 and pop:
  - rdata returns the oldest word and count stays 32.
  - Draining the remaining words yields 0x55 last.
- Empty plus simultaneous push 0x77 and pop: pop rejected, underflow=1, count=1. A next-cycle pop returns 0x77 with rvalid.
- Wrap-around and reset:
  - Run 100 random push/pop cycles and check data against a reference queue.
  - Assert rst_n=0 while count=10 with a pop in flight: next cycle rvalid=0, count=0, empty=1.
